led_matrix_serial_rx: RTL and testbench

- Receive-side decoder for the LED matrix serial link: serial data, shift clock, latch and active-low red/green column lines.
- Reconstructs the 2-colour x 8-row x 8-bit frame that the matrix driver streams out.
- Exposes the frame through a registered read port, plus per-word write strobes, a frame-complete pulse and sticky error flags.
- Used as a loopback monitor on board and as the scoreboard front-end in driver benches; all link inputs are asynchronous to clk.

---
 rtl/led_matrix_serial_rx.sv | 206 ++++++++++++++++++++
 tb/tb_led_matrix_serial_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_serial_rx.sv
// Receive-side decoder for the LED matrix serial link.
// It rebuilds the two-colour frame from the shifted row words and tracks which
// column (red or green) each word belongs to. It exposes the frame through a
// registered read port, per-word write strobes and sticky error flags.
module led_matrix_serial_rx #(
  parameter int WIDTH       = 8,
  parameter int ROWS        = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ROW_W      = $clog2(ROWS),
  localparam int ADDR_W     = ROW_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_clk,
  input  logic              ser_data,
  input  logic              ser_latch,
  input  logic              col_red_n,
  input  logic              col_green_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              frame_done,
  output logic              len_err,
  output logic              sync_err,
  input  logic              err_clr
);

  // After reset, edges are ignored until the synchronisers and the edge
  // detector's previous-value flops all hold real link levels. Without this
  // guard, a line that was already high would look like a fresh rising edge.
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SET_W  = $clog2(SETTLE + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] red_sync;
  logic [SYNC_STAGES-1:0] green_sync;

  logic clk_s;
  logic data_s;
  logic latch_s;
  logic red_s;
  logic green_s;

  logic             clk_prev;
  logic             latch_prev;
  logic [SET_W-1:0] settle_cnt;
  logic             settled;

  logic             clk_rise;
  logic             latch_rise;
  logic             red_now;
  logic             green_now;

  logic [WIDTH-1:0] sreg;
  logic [3:0]       bit_cnt;
  logic             col_ptr;
  logic [ROW_W-1:0] row_ptr;
  logic             seen_red;
  logic             seen_green;

  logic              one_flag;
  logic              obs_col;
  logic              slip;
  logic              eff_col;
  logic              last_row;
  logic [ROW_W-1:0]  next_row;
  logic [ADDR_W-1:0] commit_addr;

  logic [WIDTH-1:0] frame [2**ADDR_W];

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign latch_s = latch_sync[SYNC_STAGES-1];
  assign red_s   = red_sync[SYNC_STAGES-1];
  assign green_s = green_sync[SYNC_STAGES-1];

  // Synchronise every link input. Reset leaves the lines at their idle levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= '0;
      data_sync  <= '0;
      latch_sync <= '0;
      red_sync   <= '1;
      green_sync <= '1;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], ser_data};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], ser_latch};
      red_sync   <= {red_sync[SYNC_STAGES-2:0], col_red_n};
      green_sync <= {green_sync[SYNC_STAGES-2:0], col_green_n};
    end
  end

  // Edge detector history and the post-reset settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev   <= 1'b0;
      latch_prev <= 1'b0;
      settle_cnt <= '0;
    end else begin
      clk_prev   <= clk_s;
      latch_prev <= latch_s;
      if (!settled) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end
    end
  end

  // Edge strobes, colour observation and the commit address decision.
  always_comb begin
    settled     = (settle_cnt == SET_W'(SETTLE));
    clk_rise    = settled && clk_s && !clk_prev;
    latch_rise  = settled && latch_s && !latch_prev;
    red_now     = !red_s && green_s;
    green_now   = red_s && !green_s;
    one_flag    = seen_red ^ seen_green;
    obs_col     = seen_green;
    slip        = one_flag && (obs_col != col_ptr);
    eff_col     = slip ? obs_col : col_ptr;
    last_row    = (row_ptr == ROW_W'(ROWS - 1));
    next_row    = last_row ? '0 : row_ptr + ROW_W'(1);
    commit_addr = {eff_col, row_ptr};
  end

  // Shift register, bit counter, pointers, colour flags, errors and write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      col_ptr    <= 1'b0;
      row_ptr    <= '0;
      seen_red   <= 1'b0;
      seen_green <= 1'b0;
      len_err    <= 1'b0;
      sync_err   <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_valid   <= latch_rise;
      frame_done <= latch_rise && eff_col && last_row;

      if (clk_rise) begin
        sreg <= {sreg[WIDTH-2:0], data_s};
      end

      if (latch_rise) begin
        bit_cnt <= clk_rise ? 4'd1 : 4'd0;
      end else if (clk_rise && bit_cnt != 4'd15) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (latch_rise) begin
        wr_addr    <= commit_addr;
        wr_data    <= sreg;
        col_ptr    <= !eff_col;
        seen_red   <= 1'b0;
        seen_green <= 1'b0;
        if (eff_col) begin
          row_ptr <= next_row;
        end
      end else begin
        if (red_now) begin
          seen_red <= 1'b1;
        end
        if (green_now) begin
          seen_green <= 1'b1;
        end
      end

      if (latch_rise && bit_cnt != 4'(WIDTH)) begin
        len_err <= 1'b1;
      end else if (err_clr) begin
        len_err <= 1'b0;
      end

      if (latch_rise && slip) begin
        sync_err <= 1'b1;
      end else if (err_clr) begin
        sync_err <= 1'b0;
      end
    end
  end

  // Frame store and registered read port. A same-cycle write is not bypassed,
  // so the read returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        frame[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      rd_data <= frame[rd_addr];
      if (latch_rise) begin
        frame[commit_addr] <= sreg;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_serial_rx.sv
// Self-checking bench for led_matrix_serial_rx.
// Writes are checked by a scoreboard queue. Frame contents are checked against
// a bench-side copy of the expected frame.
module tb_led_matrix_serial_rx;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       col;
    logic       done;
  } vec_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ser_clk;
  logic       ser_data;
  logic       ser_latch;
  logic       col_red_n;
  logic       col_green_n;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;
  logic       len_err;
  logic       sync_err;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;

  exp_t       sb_q[$];
  logic [7:0] exp_frame [16];
  vec_t       vecs [16];
  logic [7:0] red_rows [8];

  led_matrix_serial_rx dut (
    .clk         (clk),
    .rst         (rst),
    .ser_clk     (ser_clk),
    .ser_data    (ser_data),
    .ser_latch   (ser_latch),
    .col_red_n   (col_red_n),
    .col_green_n (col_green_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .len_err     (len_err),
    .sync_err    (sync_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop one expectation for every committed word the DUT reports.
  always @(negedge clk) begin
    exp_t e;
    if (wr_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: actual addr=0x%0h data=0x%0h required no write", wr_addr, wr_data);
      end else begin
        e = sb_q.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(wr_data), 32'(e.data));
        checkOutput("frame_done", 32'(frame_done), 32'(e.done));
      end
    end else if (frame_done) begin
      checks++;
      failures++;
      $display("[TB] FAIL frame_done_alone: actual=1 required=0");
    end
  end

  task automatic expectWrite(input logic [3:0] addr, input logic [7:0] data, input logic done);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.done = done;
    sb_q.push_back(e);
    exp_frame[addr] = data;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick(1);
    checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic shiftBit(input logic b);
    ser_data = b;
    tick(3);
    ser_clk = 1'b1;
    tick(3);
    ser_clk = 1'b0;
  endtask

  task automatic latchPulse();
    ser_latch = 1'b1;
    tick(4);
    ser_latch = 1'b0;
    tick(4);
  endtask

  // colour: 0 drives the red column, 1 the green column, 2 neither.
  task automatic sendBits(input logic [7:0] data, input int nbits, input int colour);
    if (colour == 0) col_red_n = 1'b0;
    if (colour == 1) col_green_n = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) shiftBit(data[i]);
    col_red_n   = 1'b1;
    col_green_n = 1'b1;
    tick(3);
  endtask

  task automatic applyStimulus(input vec_t v);
    sendBits(v.data, 8, v.col ? 1 : 0);
    expectWrite(v.addr, v.data, v.done);
    latchPulse();
  endtask

  task automatic readCheck(input logic [3:0] addr, input string name);
    rd_addr = addr;
    tick(1);
    checkOutput(name, 32'(rd_data), 32'(exp_frame[addr]));
  endtask

  task automatic readAll(input string name);
    for (int a = 0; a < 16; a++) readCheck(4'(a), name);
  endtask

  task automatic doReset();
    ser_clk     = 1'b0;
    ser_data    = 1'b0;
    ser_latch   = 1'b0;
    col_red_n   = 1'b1;
    col_green_n = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);
    checkOutput("rst_sync_err", 32'(sync_err), 32'd0);
    for (int a = 0; a < 16; a++) exp_frame[a] = 8'h00;
    tick(8);
  endtask

  // Bounds the whole run so a stuck DUT cannot hang the bench.
  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    rst         = 1'b1;
    ser_clk     = 1'b0;
    ser_data    = 1'b0;
    ser_latch   = 1'b0;
    col_red_n   = 1'b1;
    col_green_n = 1'b1;
    rd_addr     = 4'd0;
    err_clr     = 1'b0;

    red_rows[0] = 8'hAA;
    for (int r = 1; r < 6; r++) red_rows[r] = 8'hF0;
    red_rows[6] = 8'h0F;
    red_rows[7] = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      vecs[i].col  = i[0];
      vecs[i].addr = {i[0], i[3:1]};
      vecs[i].data = i[0] ? 8'h0B : red_rows[i / 2];
      vecs[i].done = (i == 15);
    end

    tick(2);
    doReset();

    $display("[TB] short word");
    sendBits(8'h16, 5, 0);
    expectWrite(4'd0, 8'h16, 1'b0);
    latchPulse();
    drain();
    checkOutput("short_len_err", 32'(len_err), 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    checkOutput("short_len_err_clr", 32'(len_err), 32'd0);
    sendBits(8'h5A, 8, 1);
    expectWrite(4'd8, 8'h5A, 1'b0);
    latchPulse();
    drain();
    checkOutput("short_next_len_err", 32'(len_err), 32'd0);
    checkOutput("short_sync_err", 32'(sync_err), 32'd0);

    $display("[TB] reset mid-word");
    shiftBit(1'b1);
    shiftBit(1'b1);
    shiftBit(1'b0);
    shiftBit(1'b1);
    doReset();
    sendBits(8'h3C, 8, 0);
    expectWrite(4'd0, 8'h3C, 1'b0);
    latchPulse();
    drain();
    checkOutput("midrst_len_err", 32'(len_err), 32'd0);
    readAll("midrst_readback");

    $display("[TB] full frame");
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);
    drain();
    checkOutput("frame_len_err", 32'(len_err), 32'd0);
    checkOutput("frame_sync_err", 32'(sync_err), 32'd0);
    readAll("frame_readback");

    $display("[TB] row wrap");
    sendBits(8'h77, 8, 0);
    expectWrite(4'd0, 8'h77, 1'b0);
    latchPulse();
    drain();
    readCheck(4'd0, "wrap_addr0");
    readCheck(4'd1, "wrap_addr1");

    $display("[TB] coincident edges");
    sendBits(8'hC3, 8, 1);
    expectWrite(4'd8, 8'hC3, 1'b0);
    ser_data  = 1'b1;
    tick(3);
    ser_clk   = 1'b1;
    ser_latch = 1'b1;
    tick(4);
    ser_clk   = 1'b0;
    ser_latch = 1'b0;
    tick(4);
    drain();
    checkOutput("coinc_len_err", 32'(len_err), 32'd0);
    sendBits(8'h2A, 7, 0);
    expectWrite(4'd1, 8'hAA, 1'b0);
    latchPulse();
    drain();
    checkOutput("coinc_next_len_err", 32'(len_err), 32'd0);

    $display("[TB] colour slip");
    sendBits(8'h11, 8, 1);
    expectWrite(4'd9, 8'h11, 1'b0);
    latchPulse();
    drain();
    checkOutput("pre_slip_sync_err", 32'(sync_err), 32'd0);
    sendBits(8'h99, 8, 1);
    expectWrite(4'd10, 8'h99, 1'b0);
    latchPulse();
    drain();
    checkOutput("slip_sync_err", 32'(sync_err), 32'd1);
    sendBits(8'h22, 8, 0);
    expectWrite(4'd3, 8'h22, 1'b0);
    latchPulse();
    drain();
    checkOutput("slip_sync_err_sticky", 32'(sync_err), 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    checkOutput("slip_sync_err_clr", 32'(sync_err), 32'd0);
    checkOutput("slip_len_err", 32'(len_err), 32'd0);
    readAll("final_readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
